// File: rtl/k_rptr_empty_arb_if.sv
// Read-side bundle between the FIFO read controller and its consumers.
interface k_rptr_empty_arb_if #(
    parameter int unsigned addr_size = 4
);
    localparam int unsigned PW = addr_size + 1;

    logic [PW-1:0]        rq2_wptr;
    logic [1:0]           req;
    logic [1:0]           grant;
    logic                 rinc;
    logic [addr_size-1:0] raddr;
    logic [PW-1:0]        rptr;
    logic                 rempty;
    logic [PW-1:0]        rlevel;
    logic                 ralmost_empty;

    // Controller side: consumes the synced write pointer and requests.
    modport master (
        input  rq2_wptr, req,
        output grant, rinc, raddr, rptr, rempty, rlevel, ralmost_empty
    );

    // Environment side: drives pointer and requests, observes the rest.
    modport slave (
        output rq2_wptr, req,
        input  grant, rinc, raddr, rptr, rempty, rlevel, ralmost_empty
    );
endinterface

// File: rtl/k_rptr_empty_arb.sv
// Async FIFO read-domain controller: read pointer, empty flag, and a
// two-requester round-robin read-port arbiter with bounded bursts.
module k_rptr_empty_arb #(
    parameter int unsigned addr_size = 4,
    parameter int unsigned BURST     = 4,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                      rclk,
    input  logic                      rrst,
    k_rptr_empty_arb_if.master        bus
);
    localparam int unsigned PW = addr_size + 1;
    localparam int unsigned CW = 4;

    logic [PW-1:0] rbin_q,   rbin_d;
    logic [PW-1:0] rptr_q,   rgray_d;
    logic          rempty_q, rempty_d;
    logic          owner_q,  owner_d;
    logic [CW-1:0] cnt_q,    cnt_d;

    logic [PW-1:0] wbin;
    logic [1:0]    grant_c;
    logic          rinc_c;
    logic          other;
    logic          own_req;
    logic          oth_req;

    // Gray-to-binary of the synchronized write pointer.
    always_comb begin
        wbin = '0;
        for (int i = 0; i < PW; i++) begin
            wbin[i] = ^(bus.rq2_wptr >> i);
        end
    end

    // Round-robin arbitration; the owner yields once its burst is spent
    // and the partner is waiting. Nothing is granted while empty.
    always_comb begin
        other   = ~owner_q;
        own_req = bus.req[owner_q];
        oth_req = bus.req[other];
        grant_c = '0;
        if (!rempty_q) begin
            if (own_req && (!oth_req || (cnt_q < CW'(BURST)))) begin
                grant_c[owner_q] = 1'b1;
            end else if (oth_req) begin
                grant_c[other] = 1'b1;
            end
        end
    end

    // Next pointer, empty flag and burst bookkeeping.
    always_comb begin
        rinc_c   = |grant_c;
        rbin_d   = rbin_q + PW'(rinc_c);
        rgray_d  = (rbin_d >> 1) ^ rbin_d;
        rempty_d = (rgray_d == bus.rq2_wptr);
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        if (rinc_c) begin
            if (grant_c[owner_q]) begin
                cnt_d = (cnt_q >= CW'(BURST)) ? CW'(BURST) : cnt_q + CW'(1);
            end else begin
                owner_d = other;
                cnt_d   = CW'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            rempty_q <= 1'b1;
            owner_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rgray_d;
            rempty_q <= rempty_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.grant         = grant_c;
    assign bus.rinc          = rinc_c;
    assign bus.raddr         = rbin_q[addr_size-1:0];
    assign bus.rptr          = rptr_q;
    assign bus.rempty        = rempty_q;
    assign bus.rlevel        = wbin - rbin_q;
    assign bus.ralmost_empty = (bus.rlevel <= PW'(AE_THRESH));
endmodule

// File: tb/tb_k_rptr_empty_arb.sv
// Scoreboard bench for the read-domain controller with BURST=2.
module tb_k_rptr_empty_arb;
    localparam int unsigned AS    = 4;
    localparam int unsigned BURST = 2;
    localparam int unsigned AE    = 2;
    localparam int          DEPTH = 16;
    localparam int          PMOD  = 32;

    typedef struct packed {
        logic [1:0] grant;
        logic       rinc;
        logic [3:0] raddr;
        logic [4:0] rptr;
        logic       rempty;
        logic [4:0] rlevel;
        logic       ae;
    } exp_t;

    logic rclk = 1'b0;
    logic rrst = 1'b1;

    k_rptr_empty_arb_if #(.addr_size(AS)) bus ();

    k_rptr_empty_arb #(
        .addr_size (AS),
        .BURST     (BURST),
        .AE_THRESH (AE)
    ) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus)
    );

    always #5 rclk = ~rclk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: counts of reads and writes as plain integers.
    int rd_m     = 0;
    int wr_m     = 0;
    bit empty_m  = 1'b1;
    int owner_m  = 0;
    int streak_m = 0;

    function automatic logic [4:0] to_gray(input int v);
        int m;
        m = v % PMOD;
        return 5'(m ^ (m >> 1));
    endfunction

    // Apply one cycle of inputs, predict outputs, advance the model.
    task automatic step(input bit r, input logic [1:0] rq, input int w);
        exp_t e;
        int   g;
        int   lvl;
        int   oth;
        @(posedge rclk);
        #1;
        rrst         = r;
        bus.req      = rq;
        wr_m         = w;
        bus.rq2_wptr = to_gray(w);

        g   = -1;
        oth = 1 - owner_m;
        if (!empty_m) begin
            if (rq[owner_m] && (!rq[oth] || streak_m < BURST)) g = owner_m;
            else if (rq[oth]) g = oth;
        end
        lvl = (((wr_m - rd_m) % PMOD) + PMOD) % PMOD;
        e.grant  = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
        e.rinc   = (g >= 0);
        e.raddr  = 4'(rd_m % DEPTH);
        e.rptr   = to_gray(rd_m);
        e.rempty = empty_m;
        e.rlevel = 5'(lvl);
        e.ae     = (lvl <= AE);
        exp_q.push_back(e);

        if (r) begin
            rd_m = 0; empty_m = 1'b1; owner_m = 0; streak_m = 0;
        end else begin
            if (g >= 0) begin
                rd_m = rd_m + 1;
                if (g == owner_m) begin
                    streak_m = (streak_m >= BURST) ? BURST : streak_m + 1;
                end else begin
                    owner_m  = g;
                    streak_m = 1;
                end
            end
            empty_m = ((rd_m % PMOD) == (wr_m % PMOD));
        end
    endtask

    // Monitor: pop one expectation per cycle and compare mid-cycle.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge rclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.grant  = bus.grant;
                a.rinc   = bus.rinc;
                a.raddr  = bus.raddr;
                a.rptr   = bus.rptr;
                a.rempty = bus.rempty;
                a.rlevel = bus.rlevel;
                a.ae     = bus.ralmost_empty;
                n_checks++;
                if (a === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL outputs t=%0t got grant=%b rinc=%b raddr=%0d rptr=%b rempty=%b rlevel=%0d ae=%b expected grant=%b rinc=%b raddr=%0d rptr=%b rempty=%b rlevel=%0d ae=%b",
                             $time, a.grant, a.rinc, a.raddr, a.rptr, a.rempty, a.rlevel, a.ae,
                             e.grant, e.rinc, e.raddr, e.rptr, e.rempty, e.rlevel, e.ae);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized phase.
    initial begin
        int w;
        bit r;
        bus.req      = 2'b00;
        bus.rq2_wptr = '0;

        // Reset with requests pending, then empty hold.
        step(1'b1, 2'b11, 0);
        step(1'b1, 2'b11, 0);
        repeat (3) step(1'b0, 2'b11, 0);

        // Single-requester drain of 3 entries.
        repeat (6) step(1'b0, 2'b01, 3);

        // Burst round-robin over 8 entries.
        repeat (11) step(1'b0, 2'b11, 11);

        // Idle partner: 5 entries all to requester 1.
        repeat (7) step(1'b0, 2'b10, 16);

        // Wrap-around: reset, preload 14 reads, then 6 more across the wrap.
        step(1'b1, 2'b00, 0);
        repeat (16) step(1'b0, 2'b01, 14);
        repeat (3) step(1'b0, 2'b00, 20);
        repeat (8) step(1'b0, 2'b11, 20);

        // Reset in the third cycle of a burst, then restart.
        step(1'b1, 2'b00, 0);
        repeat (3) step(1'b0, 2'b11, 6);
        step(1'b1, 2'b11, 0);
        repeat (4) step(1'b0, 2'b11, 1);

        // Randomized traffic with legal occupancy and rare resets.
        w = wr_m;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 79) == 0);
            if (r) begin
                w = 0;
            end else begin
                w = w + int'($urandom_range(0, 2));
                if (w - rd_m > DEPTH) w = rd_m + DEPTH;
            end
            step(r, 2'($urandom_range(0, 3)), w);
        end

        @(posedge rclk);
        @(negedge rclk);
        @(negedge rclk);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain leftover=%0d expected=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/k_rptr_empty_arb.md
Name: k_rptr_empty_arb

Overview:
- Read-domain controller of the async FIFO.
- Consumes the write pointer after it has passed through the 2-flop w2r synchronizer.
- Owns the binary read address, the Gray read pointer (fed to the r2w synchronizer) and the empty flag.
- Arbitrates the single FIFO read port between two read requesters using round-robin with a bounded burst.

Parameters:
- addr_size, 4, FIFO depth is 2**addr_size; pointers are addr_size+1 bits.
- BURST, 4, maximum consecutive grants to one requester while the other is waiting (1..15).
- AE_THRESH, 2, ralmost_empty asserts when rlevel <= AE_THRESH.

Ports:
- rclk  input  1  read-domain clock; all state updates on posedge.
- rrst  input  1  synchronous active-high reset.
- rq2_wptr  input  addr_size+1  synchronized Gray write pointer.
- req  input  2  read requests; bit i belongs to requester i.
- grant  output  2  one-hot read grant; requester i takes the memory read data in the same cycle.
- rinc  output  1  read enable to the memory; equals |grant.
- raddr  output  addr_size  memory read address, rbin[addr_size-1:0].
- rptr  output  addr_size+1  registered Gray read pointer, to the r2w synchronizer.
- rempty  output  1  registered empty flag.
- rlevel  output  addr_size+1  conservative occupancy, (wbin - rbin) mod 2**(addr_size+1).
- ralmost_empty  output  1  rlevel <= AE_THRESH.

Behaviour:
- Reset (rrst high at posedge): rbin=0, rptr=0, rempty=1, owner=0, cnt=0.
  - Consequences: grant=0, rinc=0, rlevel=0, ralmost_empty=1.
  - Reset overrides any simultaneous request.
- Pointer arithmetic:
  - rbinnext = rbin + rinc, modulo 2**(addr_size+1).
  - rgraynext = (rbinnext>>1) ^ rbinnext.
  - Each posedge: rbin<=rbinnext, rptr<=rgraynext, rempty<=(rgraynext==rq2_wptr).
- Pointer timing:
  - One read advances raddr on the next cycle.
  - Wrap-around is natural: the MSB toggles every 2**addr_size reads.
- wbin is the combinational Gray-to-binary conversion of rq2_wptr.
- rlevel and ralmost_empty:
  - Combinational from the registered rbin and rq2_wptr.
  - Never exceed 2**addr_size for legal inputs.
  - Pessimistic, never optimistic, because of synchronizer delay.
- Empty deassertion: when rq2_wptr moves away from rptr, rempty falls one rclk later. No read is granted in that intervening cycle.
- Arbitration is combinational from req, owner, cnt and rempty. grant=0 whenever rempty=1.
  - If owner requests, and either the other does not request or cnt < BURST: grant owner.
  - Else if the other requests: grant the other.
  - Else: grant=0.
- Arbitration state update on a grant:
  - Same requester as owner: cnt<=min(cnt+1, BURST).
  - Switch: owner<=granted index, cnt<=1.
  - No grant: owner and cnt hold.
- grant is always one-hot or zero; never 2'b11.
- A read on the last entry: rempty rises on the next posedge, so back-to-back requests get no further grant.
- Requests may drop at any time; nothing is latched.
- Reset mid-burst discards owner/cnt and the pointers. The write side must be reset in the same episode; cross-domain reset sequencing is outside this block.

Test Plan:
- Reset, then empty hold:
  - Stimulus: assert rrst 2 cycles with req=2'b11 and rq2_wptr=0; then release.
  - Required: rempty=1, grant=0, rptr=0, raddr=0, rlevel=0, ralmost_empty=1 throughout.
- Single-requester drain:
  - Stimulus: rq2_wptr=5'b00010 (bin 3), req=2'b01.
  - Required: rempty falls 1 cycle later; grant=01 for 3 cycles with raddr 0,1,2; rempty=1 and grant=0 from the next cycle; rptr=5'b00010; rlevel 3,2,1,0.
- Burst round-robin, BURST=2:
  - Stimulus: rq2_wptr=Gray(8)=5'b01100, req=2'b11.
  - Required: grant sequence 01,01,10,10,01,01,10,10, then rempty=1; raddr 0..7.
- Idle partner:
  - Stimulus: BURST=2, req=2'b10 only, 5 entries available.
  - Required: 5 consecutive grants to requester 1 with no forced switch; cnt saturates at 2.
- Wrap-around:
  - Stimulus: preload by reading 14 entries; then rq2_wptr=Gray(20)=5'b11110; drain.
  - Required: raddr runs 14,15,0,1,2,3; rptr passes 5'b11000 at bin 16; rempty asserts when rptr=5'b11110; rlevel=6 at drain start.
- Reset mid-operation:
  - Stimulus: rrst asserted in the 3rd cycle of a burst.
  - Required: the next cycle shows rbin=0, rptr=0, rempty=1, grant=0; after release with rq2_wptr=Gray(1), the first grant goes to requester 0 when req=2'b11.
